// File: rtl/crc_frame_scheduler_pkg.sv
// ============================================================================
//  Module      : crc_frame_scheduler_pkg
//  Description : Shared widths, FSM state encoding and helpers for the
//                two-requester CRC-16 framing scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package crc_frame_scheduler_pkg;

  localparam int PAYLOAD_W = 34;
  localparam int PAD_W     = 40;
  localparam int CRC_W     = 16;
  localparam int CODE_W    = 50;
  localparam int NUM_BYTES = 5;
  localparam int CNT_W     = 3;

  // Counter value on which the final byte of the padded payload is folded in
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Zero-extend a payload to a whole number of bytes
  function automatic logic [PAD_W-1:0] pad_payload(input logic [PAYLOAD_W-1:0] p);
    return {{(PAD_W - PAYLOAD_W){1'b0}}, p};
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_frame_scheduler_crc16_byte_step.sv
// ============================================================================
//  Module      : crc16_byte_step
//  Description : Combinational CRC-16 update over one byte, MSB first,
//                non-reflected, with a run-time polynomial.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module crc16_byte_step (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_byte,
  input  logic [15:0] poly,
  output logic [15:0] crc_out
);

  // Fold the byte into the top of the register, then shift out eight bits
  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {data_byte, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = (c << 1) ^ poly;
      end else begin
        c = c << 1;
      end
    end
    crc_out = c;
  end

endmodule

`default_nettype wire

// File: rtl/crc_frame_scheduler.sv
// ============================================================================
//  Module      : crc_frame_scheduler
//  Description : Accepts 34-bit words from two requesters, appends a CRC-16
//                computed one byte per cycle, and presents the 50-bit
//                codeword until downstream accepts it.
//                Build option: define CRC_RR_ARB_EN for round-robin
//                arbitration; otherwise req0 has fixed priority.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module crc_frame_scheduler
  import crc_frame_scheduler_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_INIT = 16'h0000,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [PAYLOAD_W-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [PAYLOAD_W-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [CODE_W-1:0]    out_data,
  output logic                 out_chan,
  input  logic                 out_ready,
  output logic                 busy
);

  state_t               state_q;
  logic [CRC_W-1:0]     crc_q;
  logic [CRC_W-1:0]     crc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [PAD_W-1:0]     pad_q;
  logic                 chan_q;
  logic                 out_valid_q;
  logic [CODE_W-1:0]    out_data_q;
  logic                 out_chan_q;

  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_idle_ok;
  logic                 w_accept;
  logic                 w_sel;
  logic [PAYLOAD_W-1:0] w_data;
  logic [7:0]           w_byte;

`ifdef CRC_RR_ARB_EN
  // 1 means req1 received the most recent grant
  logic last_q;

  // Round-robin: on a tie, favour the requester not served last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt0 = last_q;
      w_gnt1 = ~last_q;
    end else begin
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid;
    end
  end

  // Remember who was granted; reset treats req1 as last so req0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (w_accept) begin
      last_q <= w_sel;
    end
  end
`else
  // Fixed priority: req0 always wins a tie
  always_comb begin
    w_gnt0 = req0_valid;
    w_gnt1 = req1_valid & ~req0_valid;
  end
`endif

  // Ready only in IDLE, and held low while reset is asserted
  assign w_idle_ok  = (state_q == S_IDLE) & ~reset;
  assign req0_ready = w_idle_ok & w_gnt0;
  assign req1_ready = w_idle_ok & w_gnt1;
  assign w_accept   = req0_ready | req1_ready;
  assign w_sel      = req1_ready;
  assign w_data     = w_sel ? req1_data : req0_data;

  // Select the byte for this COMPUTE cycle, most significant byte first
  always_comb begin
    w_byte = 8'h00;
    case (cnt_q)
      3'd0:    w_byte = pad_q[39:32];
      3'd1:    w_byte = pad_q[31:24];
      3'd2:    w_byte = pad_q[23:16];
      3'd3:    w_byte = pad_q[15:8];
      3'd4:    w_byte = pad_q[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  crc16_byte_step u_step (
    .crc_in    (crc_q),
    .data_byte (w_byte),
    .poly      (CRC_POLY),
    .crc_out   (crc_d)
  );

  // Main sequencer: accept, fold five bytes, then hold the codeword
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      pad_q       <= '0;
      chan_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            pad_q   <= pad_payload(w_data);
            chan_q  <= w_sel;
            crc_q   <= CRC_INIT;
            cnt_q   <= '0;
            state_q <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          crc_q <= crc_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= {pad_q[PAYLOAD_W-1:0], crc_d};
            out_chan_q  <= chan_q;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc_frame_scheduler.sv
`default_nettype none

module tb_crc_frame_scheduler;

  localparam logic [15:0] INIT = 16'h0000;
  localparam logic [15:0] POLY = 16'h1021;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [33:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [33:0] req1_data = '0;
  logic        req1_ready;
  logic        out_valid;
  logic [49:0] out_data;
  logic        out_chan;
  logic        out_ready = 1'b1;
  logic        busy;

  int total = 0;
  int bad   = 0;

  crc_frame_scheduler #(.CRC_INIT(INIT), .CRC_POLY(POLY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Reference CRC: bit-serial long division of the 40-bit zero-extended word
  function automatic logic [15:0] crc_ref(input logic [33:0] p);
    logic [39:0] m;
    logic [15:0] c;
    logic        fb;
    m = {6'b0, p};
    c = INIT;
    for (int i = 39; i >= 0; i--) begin
      fb = c[15] ^ m[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Arbitration rule: returns {any_grant, granted_channel}
  function automatic logic [1:0] arb(input logic v0, input logic v1, input logic last);
    if (!v0 && !v1) return 2'b00;
    if (v0 && v1) begin
`ifdef CRC_RR_ARB_EN
      return {1'b1, ~last};
`else
      return {1'b1, 1'b0 & last};
`endif
    end
    return {1'b1, v1};
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_busy, m_valid, m_chan, m_out_chan, m_last;
  int          m_timer;
  logic [49:0] m_code, m_out_data;
  logic [1:0]  w_arb;

  assign w_arb = arb(req0_valid, req1_valid, m_last);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_valid    <= 1'b0;
      m_timer    <= 0;
      m_chan     <= 1'b0;
      m_code     <= '0;
      m_out_data <= '0;
      m_out_chan <= 1'b0;
      m_last     <= 1'b1;
    end else if (!m_busy) begin
      if (w_arb[1]) begin
        m_busy  <= 1'b1;
        m_timer <= 0;
        m_chan  <= w_arb[0];
        m_last  <= w_arb[0];
        m_code  <= w_arb[0] ? {req1_data, crc_ref(req1_data)} : {req0_data, crc_ref(req0_data)};
      end
    end else if (!m_valid) begin
      // Codeword appears in the sixth cycle after the accepting edge
      m_timer <= m_timer + 1;
      if (m_timer == 4) begin
        m_valid    <= 1'b1;
        m_out_data <= m_code;
        m_out_chan <= m_chan;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("req0_ready", req0_ready, !reset && !m_busy && w_arb[1] && !w_arb[0]);
    check("req1_ready", req1_ready, !reset && !m_busy && w_arb[1] && w_arb[0]);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, m_valid);
    if (m_valid || reset) begin
      check("out_data", out_data, m_out_data);
      check("out_chan", out_chan, m_out_chan);
    end
  end

  // ---------------- handshake log from the DUT ports ----------------
  int cyc = 0;
  int hs_n = 0;
  bit hs_ch [64];
  int hs_t  [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && hs_n < 64) begin
      if (req0_valid && req0_ready) begin
        hs_ch[hs_n] <= 1'b0;
        hs_t[hs_n]  <= cyc;
        hs_n        <= hs_n + 1;
      end else if (req1_valid && req1_ready) begin
        hs_ch[hs_n] <= 1'b1;
        hs_t[hs_n]  <= cyc;
        hs_n        <= hs_n + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic present(input bit ch, input logic [33:0] d);
    if (ch) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
  endtask

  task automatic wait_hs(input bit ch);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = ch ? req1_ready : req0_ready;
    end
    if (!got) timeout("handshake");
    @(posedge clk);
    #1;
    // Drop valid and scramble data: the result must use the sampled word
    if (ch) begin
      req1_valid = 1'b0;
      req1_data  = 34'h2_AAAA_AAAA;
    end else begin
      req0_valid = 1'b0;
      req0_data  = 34'h1_5555_5555;
    end
  endtask

  task automatic wait_out(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) timeout("out_valid");
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          lat;
    int          base;
    logic [49:0] cap_d;
    logic        cap_c;
    logic [3:0]  exp_seq;

    // Pin the reference model to known CRC-16/XMODEM values
    check("ref_crc_0", crc_ref(34'h0), 16'h0000);
    check("ref_crc_1", crc_ref(34'h1), 16'h1021);
    check("ref_crc_ff", crc_ref(34'hFF), 16'h1EF0);

    // Reset state, with a requester already waiting
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 50'h0);
    check("rst_out_chan", out_chan, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b0);
    step();
    reset      = 1'b0;
    req0_valid = 1'b0;
    step();

    // All-zero word from req0
    present(1'b0, 34'h0);
    wait_hs(1'b0);
    wait_out(lat);
    check("t0_latency", lat, 6);
    check("t0_data", out_data, 50'h0);
    check("t0_chan", out_chan, 1'b0);
    step();

    // Word 1 from req1
    present(1'b1, 34'h1);
    wait_hs(1'b1);
    wait_out(lat);
    check("t1_data", out_data, {34'h1, 16'h1021});
    check("t1_chan", out_chan, 1'b1);
    step();

    // Word 0xFF from req0
    present(1'b0, 34'hFF);
    wait_hs(1'b0);
    wait_out(lat);
    check("tff_data", out_data, {34'hFF, 16'h1EF0});
    check("tff_chan", out_chan, 1'b0);
    step();

    // Downstream stall for 10 cycles with another requester waiting
    out_ready = 1'b0;
    present(1'b0, 34'h3_2345_6789);
    wait_hs(1'b0);
    wait_out(lat);
    check("stall_data", out_data, {34'h3_2345_6789, crc_ref(34'h3_2345_6789)});
    cap_d = out_data;
    cap_c = out_chan;
    step();
    present(1'b1, 34'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_hold_data", out_data, cap_d);
      check("stall_hold_chan", out_chan, cap_c);
      check("stall_no_grant", req1_ready, 1'b0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("no_bypass_ready", req1_ready, 1'b0);
    wait_hs(1'b1);
    wait_out(lat);
    check("a5_data", out_data, {34'hA5, crc_ref(34'hA5)});
    step();

    // Reset while COMPUTE is at count 2 discards the word
    present(1'b0, 34'h3);
    wait_hs(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("postrst_busy", busy, 1'b0);
    check("postrst_valid", out_valid, 1'b0);
    step();
    present(1'b1, 34'h1);
    wait_hs(1'b1);
    wait_out(lat);
    check("postrst_latency", lat, 6);
    check("postrst_data", out_data, {34'h1, 16'h1021});
    step();

    // Both requesters continuously valid for four words
    base = hs_n;
    present(1'b0, 34'h0_DEAD_BEEF);
    present(1'b1, 34'h3_0000_0011);
    for (int i = 0; i < 200; i++) begin
      step();
      if (hs_n - base >= 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (hs_n - base < 4) timeout("tie_words");
    repeat (10) step();
`ifdef CRC_RR_ARB_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      check("tie_grant", hs_ch[base + i], exp_seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      check("tie_spacing", hs_t[base + i + 1] - hs_t[base + i], 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
